// File: rtl/collision_pair_scheduler.sv
// Sweeps every ball pair (i<j), tests overlap and runs the shared rectify unit with write-back.
// Optional build macro COLLISION_SCHED_TIMEOUT_EN bounds the rectify wait to TIMEOUT cycles.
module collision_pair_scheduler #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FRAC_WIDTH = 30,
    parameter int unsigned N_BALLS    = 16,
    parameter int unsigned TIMEOUT    = 64,
    localparam int unsigned IDX_W     = $clog2(N_BALLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] radius,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rect_count,
    output logic [IDX_W-1:0] rd_idx,
    input  logic [WIDTH-1:0] rd_x,
    input  logic [WIDTH-1:0] rd_y,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic [WIDTH-1:0] wr_x,
    output logic [WIDTH-1:0] wr_y,
    output logic             rect_start,
    output logic [WIDTH-1:0] rect_x0,
    output logic [WIDTH-1:0] rect_y0,
    output logic [WIDTH-1:0] rect_x1,
    output logic [WIDTH-1:0] rect_y1,
    output logic [WIDTH-1:0] rect_radius,
    input  logic             rect_done,
    input  logic [WIDTH-1:0] rect_nx0,
    input  logic [WIDTH-1:0] rect_ny0,
    input  logic [WIDTH-1:0] rect_nx1,
    input  logic [WIDTH-1:0] rect_ny1,
    output logic             timeout_err
);

    if (N_BALLS < 2 || TIMEOUT < 1) begin : g_param_check
        $error("collision_pair_scheduler: needs N_BALLS >= 2 and TIMEOUT >= 1");
    end

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_RD_A       = 4'd1;
    localparam logic [3:0] S_RD_B       = 4'd2;
    localparam logic [3:0] S_LAT_B      = 4'd3;
    localparam logic [3:0] S_CHECK      = 4'd4;
    localparam logic [3:0] S_RECT_START = 4'd5;
    localparam logic [3:0] S_RECT_WAIT  = 4'd6;
    localparam logic [3:0] S_WB_A       = 4'd7;
    localparam logic [3:0] S_WB_B       = 4'd8;
    localparam logic [3:0] S_NEXT       = 4'd9;
    localparam logic [3:0] S_FIN        = 4'd10;

    logic [3:0]              state;
    logic [3:0]              state_next;
    logic [IDX_W-1:0]        idx_i;
    logic [IDX_W-1:0]        idx_j;
    logic [IDX_W-1:0]        i_adv;
    logic [IDX_W-1:0]        j_adv;
    logic signed [WIDTH-1:0] xa;
    logic signed [WIDTH-1:0] ya;
    logic signed [WIDTH-1:0] xb;
    logic signed [WIDTH-1:0] yb;
    logic signed [WIDTH-1:0] dx;
    logic signed [WIDTH-1:0] dy;
    logic signed [WIDTH-1:0] two_r;
    logic signed [WIDTH-1:0] thresh;
    logic signed [WIDTH:0]   dist2;
    logic                    overlap;
    logic                    last_pair;
    logic                    take_done;
    logic                    wait_first;
    logic                    wait_expired;

    // Fixed-point multiply: full-width product, arithmetic shift, truncate back to WIDTH.
    function automatic logic signed [WIDTH-1:0] fxmul(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        return WIDTH'(p >>> FRAC_WIDTH);
    endfunction

    // Squared distance gets one guard bit so large separations cannot wrap into a false overlap.
    always_comb begin : overlap_calc
        dx      = xa - xb;
        dy      = ya - yb;
        two_r   = $signed(rect_radius) <<< 1;
        thresh  = fxmul(two_r, two_r);
        dist2   = (WIDTH+1)'(fxmul(dx, dx)) + (WIDTH+1)'(fxmul(dy, dy));
        overlap = dist2 < (WIDTH+1)'(thresh);
    end

    always_comb begin : pair_advance
        last_pair = (idx_i == IDX_W'(N_BALLS - 2)) && (idx_j == IDX_W'(N_BALLS - 1));
        if (idx_j == IDX_W'(N_BALLS - 1)) begin
            i_adv = idx_i + IDX_W'(1);
            j_adv = idx_i + IDX_W'(2);
        end else begin
            i_adv = idx_i;
            j_adv = idx_j + IDX_W'(1);
        end
    end

    // The first wait cycle still shows the previous operation's done level.
    assign take_done = !wait_first && rect_done;

    always_ff @(posedge clk) begin : state_reg
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin : next_state
        state_next = state;
        case (state)
            S_IDLE:       if (start) state_next = S_RD_A;
            S_RD_A:       state_next = S_RD_B;
            S_RD_B:       state_next = S_LAT_B;
            S_LAT_B:      state_next = S_CHECK;
            S_CHECK:      state_next = overlap ? S_RECT_START : S_NEXT;
            S_RECT_START: state_next = S_RECT_WAIT;
            S_RECT_WAIT: begin
                if (take_done)         state_next = S_WB_A;
                else if (wait_expired) state_next = S_NEXT;
            end
            S_WB_A:       state_next = S_WB_B;
            S_WB_B:       state_next = S_NEXT;
            S_NEXT:       state_next = last_pair ? S_FIN : S_RD_A;
            S_FIN:        state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_en       <= 1'b0;
            rect_start  <= 1'b0;
            rect_count  <= '0;
            rd_idx      <= '0;
            wr_idx      <= '0;
            wr_x        <= '0;
            wr_y        <= '0;
            rect_x0     <= '0;
            rect_y0     <= '0;
            rect_x1     <= '0;
            rect_y1     <= '0;
            rect_radius <= '0;
            idx_i       <= '0;
            idx_j       <= '0;
            xa          <= '0;
            ya          <= '0;
            xb          <= '0;
            yb          <= '0;
        end else begin
            busy       <= (state_next != S_IDLE) && (state_next != S_FIN);
            done       <= (state_next == S_FIN);
            rect_start <= (state_next == S_RECT_START);
            wr_en      <= (state_next == S_WB_A) || (state_next == S_WB_B);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rect_radius <= radius;
                        rect_count  <= '0;
                        idx_i       <= '0;
                        idx_j       <= IDX_W'(1);
                        rd_idx      <= '0;
                    end
                end
                S_RD_A: rd_idx <= idx_j;
                S_RD_B: begin
                    xa <= rd_x;
                    ya <= rd_y;
                end
                S_LAT_B: begin
                    xb <= rd_x;
                    yb <= rd_y;
                end
                S_CHECK: begin
                    if (overlap) begin
                        rect_x0 <= xa;
                        rect_y0 <= ya;
                        rect_x1 <= xb;
                        rect_y1 <= yb;
                    end
                end
                S_RECT_WAIT: begin
                    if (take_done) begin
                        wr_idx <= idx_i;
                        wr_x   <= rect_nx0;
                        wr_y   <= rect_ny0;
                    end
                end
                S_WB_A: begin
                    wr_idx <= idx_j;
                    wr_x   <= rect_nx1;
                    wr_y   <= rect_ny1;
                end
                S_WB_B: begin
                    if (rect_count != 8'hFF) rect_count <= rect_count + 8'd1;
                end
                S_NEXT: begin
                    idx_i  <= i_adv;
                    idx_j  <= j_adv;
                    rd_idx <= i_adv;
                end
                default: ;
            endcase
        end
    end

`ifdef COLLISION_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt;

    assign wait_first   = (wait_cnt == '0);
    assign wait_expired = (wait_cnt == TO_W'(TIMEOUT - 1));

    // Counts cycles spent in RECT_WAIT; expiry skips the pair and flags a sticky error.
    always_ff @(posedge clk) begin : wait_timer
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= (state == S_RECT_WAIT) ? wait_cnt + TO_W'(1) : '0;
            if ((state == S_RECT_WAIT) && !take_done && wait_expired) timeout_err <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;

    always_ff @(posedge clk) begin : wait_flag
        if (rst) wait_first <= 1'b1;
        else     wait_first <= (state != S_RECT_WAIT);
    end
`endif

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Scoreboard bench for collision_pair_scheduler: 4-ball store, behavioural rectify unit.
module tb_collision_pair_scheduler;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned NB    = 4;
    localparam int unsigned TO    = 8;

    // Q2.30 constants
    localparam logic [31:0] R     = 32'd53687091;   // 0.05
    localparam logic [31:0] X010  = 32'd107374182;  // 0.10
    localparam logic [31:0] X015  = 32'd161061273;  // 0.15
    localparam logic [31:0] X020  = 32'd214748364;  // 0.20
    localparam logic [31:0] X025  = 32'd268435456;  // 0.25
    localparam logic [31:0] X030  = 32'd322122547;  // 0.30
    localparam logic [31:0] X050  = 32'd536870912;  // 0.50
    localparam logic [31:0] X060  = 32'd644245094;  // 0.60
    localparam logic [31:0] X075  = 32'd805306368;  // 0.75
    localparam logic [31:0] X090  = 32'd966367641;  // 0.90
    localparam logic [31:0] STALE = 32'h0BAD0BAD;

    logic        clk = 1'b0;
    logic        rst, start, rect_done, busy, done, wr_en, rect_start, timeout_err;
    logic [31:0] radius, rd_x, rd_y, wr_x, wr_y;
    logic [31:0] rect_x0, rect_y0, rect_x1, rect_y1, rect_radius;
    logic [31:0] rect_nx0, rect_ny0, rect_nx1, rect_ny1;
    logic [7:0]  rect_count;
    logic [1:0]  rd_idx, wr_idx;

    always #5 clk = ~clk;

    collision_pair_scheduler #(
        .WIDTH(WIDTH), .FRAC_WIDTH(30), .N_BALLS(NB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .radius(radius),
        .busy(busy), .done(done), .rect_count(rect_count),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .rect_start(rect_start), .rect_x0(rect_x0), .rect_y0(rect_y0),
        .rect_x1(rect_x1), .rect_y1(rect_y1), .rect_radius(rect_radius),
        .rect_done(rect_done), .rect_nx0(rect_nx0), .rect_ny0(rect_ny0),
        .rect_nx1(rect_nx1), .rect_ny1(rect_ny1), .timeout_err(timeout_err)
    );

    typedef struct { logic [1:0] idx; logic [31:0] x; logic [31:0] y; } wr_t;

    wr_t         wq[$];
    logic [31:0] dq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Position store: one-cycle read latency, bulk load from the bench.
    logic [31:0] mx[NB], my[NB], ix[NB], iy[NB];
    logic        load;
    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NB; k++) begin
                mx[k] <= ix[k];
                my[k] <= iy[k];
            end
        end else if (wr_en) begin
            mx[wr_idx] <= wr_x;
            my[wr_idx] <= wr_y;
        end
        rd_x <= mx[rd_idx];
        rd_y <= my[rd_idx];
    end

    // Rectify unit model: pushes ball 0 left and ball 1 right by R after rect_delay cycles.
    logic stale_mode, preset_done, rbusy;
    int   rect_delay, rcnt;
    always @(posedge clk) begin
        if (rst) begin
            rect_done <= 1'b0; rbusy <= 1'b0; rcnt <= 0;
            rect_nx0 <= '0; rect_ny0 <= '0; rect_nx1 <= '0; rect_ny1 <= '0;
        end else if (preset_done) begin
            rect_done <= 1'b1; rbusy <= 1'b0;
            rect_nx0 <= STALE; rect_ny0 <= STALE; rect_nx1 <= STALE; rect_ny1 <= STALE;
        end else if (rect_start) begin
            rbusy <= 1'b1;
            rcnt  <= 0;
            if (!stale_mode) rect_done <= 1'b0;
        end else if (rbusy) begin
            rcnt <= rcnt + 1;
            if (rcnt == 0) rect_done <= 1'b0;
            if (rect_delay != 0 && rcnt + 1 == rect_delay) begin
                rect_done <= 1'b1;
                rbusy     <= 1'b0;
                rect_nx0  <= rect_x0 - R;
                rect_ny0  <= rect_y0;
                rect_nx1  <= rect_x1 + R;
                rect_ny1  <= rect_y1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT writes or signals done.
    wr_t         me;
    logic [31:0] mc;
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            check("write_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                me = wq.pop_front();
                check("wr_idx", 32'(wr_idx), 32'(me.idx));
                check("wr_x", wr_x, me.x);
                check("wr_y", wr_y, me.y);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_expected", 32'(dq.size() != 0), 32'd1);
            if (dq.size() != 0) begin
                mc = dq.pop_front();
                check("rect_count", 32'(rect_count), mc);
            end
            check("busy_at_done", 32'(busy), 32'd0);
        end
        if (rect_start === 1'b1) start_cnt++;
    end

    task automatic load_balls(input logic [31:0] x0, y0, x1, y1, x2, y2, x3, y3);
        ix[0] = x0; iy[0] = y0; ix[1] = x1; iy[1] = y1;
        ix[2] = x2; iy[2] = y2; ix[3] = x3; iy[3] = y3;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic exp_wr(input logic [1:0] idx, input logic [31:0] x, input logic [31:0] y);
        wr_t e;
        e.idx = idx; e.x = x; e.y = y;
        wq.push_back(e);
    endtask

    task automatic sweep(input string name, input int exp_starts, input logic [31:0] exp_count,
                         input bit extra_start);
        int d0, s0, c;
        d0 = done_cnt;
        s0 = start_cnt;
        dq.push_back(exp_count);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        for (c = 0; c < 400 && done_cnt == d0; c++) begin
            @(posedge clk); #1;
            start = extra_start && (c == 5);
        end
        start = 1'b0;
        repeat (extra_start ? 40 : 3) @(posedge clk);
        #1;
        check({name, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, " rect_starts"}, 32'(start_cnt - s0), 32'(exp_starts));
        check({name, " writes_left"}, 32'(wq.size()), 32'd0);
        wq.delete();
        dq.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, c;
        rst = 1'b1; start = 1'b0; radius = R; load = 1'b0;
        preset_done = 1'b0; stale_mode = 1'b0; rect_delay = 3;
        for (int k = 0; k < NB; k++) begin ix[k] = '0; iy[k] = '0; end
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst rect_start", 32'(rect_start), 32'd0);
        check("rst rect_count", 32'(rect_count), 32'd0);
        check("rst rd_idx", 32'(rd_idx), 32'd0);
        check("rst wr_idx", 32'(wr_idx), 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        check("rst rect_x0", rect_x0, 32'd0);
        check("rst rect_radius", rect_radius, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Spread 0.25 apart: no overlaps; second start mid-sweep must be ignored
        load_balls('0, X050, X025, X050, X050, X050, X075, X050);
        sweep("spread", 0, 32'd0, 1'b1);

        // One overlapping pair (0,1)
        load_balls(X010, X050, X015, X050, X060, X020, X090, X090);
        exp_wr(2'd0, X010 - R, X050);
        exp_wr(2'd1, X015 + R, X050);
        sweep("overlap", 1, 32'd1, 1'b0);
        check("overlap rect_radius", rect_radius, R);
        check("overlap timeout_err", 32'(timeout_err), 32'd0);

        // Exact touch (dx == 2r) is not an overlap
        load_balls(X030, X050, X030 + 2 * R, X050, X060, X020, X090, X090);
        sweep("touch", 0, 32'd0, 1'b0);

        // Just inside touching distance
        load_balls(X030, X050, X030 + 2 * R - 32'd1024, X050, X060, X020, X090, X090);
        exp_wr(2'd0, X030 - R, X050);
        exp_wr(2'd1, X030 + 3 * R - 32'd1024, X050);
        sweep("inside", 1, 32'd1, 1'b0);

        // Stale done level held across rect_start must not be taken
        load_balls(X010, X050, X015, X050, X060, X020, X090, X090);
        stale_mode = 1'b1; rect_delay = 2;
        preset_done = 1'b1;
        @(posedge clk); #1;
        preset_done = 1'b0;
        exp_wr(2'd0, X010 - R, X050);
        exp_wr(2'd1, X015 + R, X050);
        sweep("stale", 1, 32'd1, 1'b0);
        stale_mode = 1'b0;

        // Reset while waiting on the rectify unit
        load_balls(X010, X050, X015, X050, X060, X020, X090, X090);
        rect_delay = 20;
        s0 = start_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (c = 0; c < 200 && start_cnt == s0; c++) begin
            @(posedge clk); #1;
        end
        check("midrst rect_start_seen", 32'(start_cnt - s0), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst rect_count", 32'(rect_count), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        rect_delay = 3;
        exp_wr(2'd0, X010 - R, X050);
        exp_wr(2'd1, X015 + R, X050);
        sweep("rerun", 1, 32'd1, 1'b0);

`ifdef COLLISION_SCHED_TIMEOUT_EN
        // Rectify never completes: pair skipped, sweep completes, sticky error
        load_balls(X010, X050, X015, X050, X060, X020, X090, X090);
        rect_delay = 0;
        sweep("timeout", 1, 32'd0, 1'b0);
        check("timeout timeout_err", 32'(timeout_err), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
